// File: rtl/seq_divider_4.sv
// Iterative restoring divider: one quotient bit per cycle, results registered on the last iteration.
// Optional feature macro DIVZERO_CHECK_EN: a zero divisor short-circuits to DONE and raises DivZero_out.
module seq_divider_4 #(
    parameter int WIDTH = 4
) (
    input  logic             Clk_in,
    input  logic             Reset_in,
    input  logic             Start_in,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out,
    output logic             Busy_out,
    output logic             Done_out,
    output logic             DivZero_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] quo_sh_s;
    logic [WIDTH+1:0] trial_s;
    logic             no_borrow_s;
    logic [WIDTH:0]   rem_nxt_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic             zero_start_s;

    // Two's-complement subtract r - d; bit WIDTH+1 is the carry out (1 = no borrow).
    function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH:0] r, input logic [WIDTH-1:0] d);
        trial_sub = {1'b0, r} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
    endfunction

`ifdef DIVZERO_CHECK_EN
    assign zero_start_s = (Divisor_in == {WIDTH{1'b0}});
`else
    assign zero_start_s = 1'b0;
`endif

    assign rem_sh_s    = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    assign quo_sh_s    = {quo_r[WIDTH-2:0], 1'b0};
    assign trial_s     = trial_sub(rem_sh_s, div_r);
    // A set top bit would mean the shifted remainder overflowed, so the subtract must succeed.
    assign no_borrow_s = trial_s[WIDTH+1] | rem_r[WIDTH];

    // One restoring-division iteration: keep the difference or restore the shifted remainder.
    always_comb begin
        rem_nxt_s = rem_sh_s;
        quo_nxt_s = quo_sh_s;
        if (no_borrow_s) begin
            rem_nxt_s = trial_s[WIDTH:0];
            quo_nxt_s = {quo_sh_s[WIDTH-1:1], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s;
            quo_nxt_s = quo_sh_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start_in) begin
                    if (zero_start_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register with registered status outputs derived from the next state.
    always_ff @(posedge Clk_in) begin
        if (Reset_in) begin
            state_r  <= IDLE;
            Busy_out <= 1'b0;
            Done_out <= 1'b0;
        end else begin
            state_r  <= state_s;
            Busy_out <= (state_s != IDLE);
            Done_out <= (state_s == DONE);
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge Clk_in) begin
        if (Reset_in) begin
            rem_r         <= {(WIDTH+1){1'b0}};
            quo_r         <= {WIDTH{1'b0}};
            div_r         <= {WIDTH{1'b0}};
            cnt_r         <= {CW{1'b0}};
            Quotient_out  <= {WIDTH{1'b0}};
            Remainder_out <= {WIDTH{1'b0}};
            DivZero_out   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start_in) begin
                        quo_r <= Dividend_in;
                        div_r <= Divisor_in;
                        rem_r <= {(WIDTH+1){1'b0}};
                        cnt_r <= CNT_LOAD;
                        if (zero_start_s) begin
                            Quotient_out  <= {WIDTH{1'b1}};
                            Remainder_out <= Dividend_in;
                            DivZero_out   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        Quotient_out  <= quo_nxt_s;
                        Remainder_out <= rem_nxt_s[WIDTH-1:0];
                        DivZero_out   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_4.sv
// Scoreboard bench for seq_divider_4: driver pushes plain-arithmetic expectations, monitor checks on Done_out.
module tb_seq_divider_4;

    localparam int W    = 4;
    localparam int MAPN = 8192;

    logic         clk = 1'b0;
    logic         Reset_in;
    logic         Start_in;
    logic [W-1:0] Dividend_in;
    logic [W-1:0] Divisor_in;
    logic [W-1:0] Quotient_out;
    logic [W-1:0] Remainder_out;
    logic         Busy_out;
    logic         Done_out;
    logic         DivZero_out;

    seq_divider_4 #(.WIDTH(W)) dut (
        .Clk_in        (clk),
        .Reset_in      (Reset_in),
        .Start_in      (Start_in),
        .Dividend_in   (Dividend_in),
        .Divisor_in    (Divisor_in),
        .Quotient_out  (Quotient_out),
        .Remainder_out (Remainder_out),
        .Busy_out      (Busy_out),
        .Done_out      (Done_out),
        .DivZero_out   (DivZero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int dz;
        int done_c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   busy_map [MAPN];
    bit   done_map [MAPN];
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   hold_q  = 0;
    int   hold_r  = 0;
    int   hold_dz = 0;
    bit   mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference: floor division and modulo; zero divisor gives all ones and the dividend.
    task automatic push_op(input int a, input int b, output int lat);
        exp_t e;
        int   k0;
        k0   = cyc + 1;
        lat  = W;
        e.dz = 0;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
`ifdef DIVZERO_CHECK_EN
        if (b == 0) begin
            e.dz = 1;
            lat  = 0;
        end
`endif
        e.done_c = k0 + lat;
        for (int k = k0; k <= k0 + lat; k++) begin
            if (k < MAPN) busy_map[k] = 1'b1;
        end
        if (e.done_c < MAPN) done_map[e.done_c] = 1'b1;
        sb.push_back(e);
    endtask

    // Issue one op, wiggle Start_in/operands while it runs, then leave the DUT idle for gap cycles.
    task automatic issue_op(input int a, input int b, input int gap);
        int lat;
        Start_in    = 1'b1;
        Dividend_in = W'(a);
        Divisor_in  = W'(b);
        push_op(a, b, lat);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            Start_in    = 1'($urandom_range(1, 0));
            Dividend_in = W'($urandom_range(15, 0));
            Divisor_in  = W'($urandom_range(15, 0));
        end
        @(negedge clk);
        Start_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_quotient"},  Quotient_out,  0);
        chk({tag, "_remainder"}, Remainder_out, 0);
        chk({tag, "_busy"},      Busy_out,      0);
        chk({tag, "_done"},      Done_out,      0);
        chk({tag, "_divzero"},   DivZero_out,   0);
    endtask

    // Monitor: cycle-accurate Busy/Done, result pop on Done, and result hold between loads.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc < MAPN) begin
                chk("busy_timing", Busy_out, busy_map[cyc]);
                chk("done_timing", Done_out, done_map[cyc]);
            end
            if (Done_out === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", Done_out, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("quotient",   Quotient_out,  mon_e.q);
                    chk("remainder",  Remainder_out, mon_e.r);
                    chk("divzero",    DivZero_out,   mon_e.dz);
                    chk("done_cycle", cyc,           mon_e.done_c);
                    hold_q  = mon_e.q;
                    hold_r  = mon_e.r;
                    hold_dz = mon_e.dz;
                end
            end
            chk("quotient_hold",  Quotient_out,  hold_q);
            chk("remainder_hold", Remainder_out, hold_r);
            chk("divzero_hold",   DivZero_out,   hold_dz);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w;
        int pa [256];
        int pb [256];
        int np;

        Reset_in    = 1'b1;
        Start_in    = 1'b0;
        Dividend_in = '0;
        Divisor_in  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        Reset_in = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk);

        issue_op(13, 3, 1);
        issue_op(15, 1, 0);
        issue_op(5, 7, 2);
        issue_op(0, 9, 0);
        issue_op(15, 15, 1);
        issue_op(9, 0, 1);

        // Reset two iterations into an op: the op is dropped and everything returns to zero.
        Start_in    = 1'b1;
        Dividend_in = 4'd11;
        Divisor_in  = 4'd2;
        push_op(11, 2, lat);
        @(negedge clk);
        Start_in = 1'b0;
        repeat (2) @(negedge clk);
        Reset_in = 1'b1;
        sb.delete();
        for (int k = cyc + 1; k <= cyc + W + 2; k++) begin
            if (k < MAPN) begin
                busy_map[k] = 1'b0;
                done_map[k] = 1'b0;
            end
        end
        @(posedge clk);
        hold_q  = 0;
        hold_r  = 0;
        hold_dz = 0;
        @(negedge clk);
        chk_reset_outputs("midcalc_reset");
        Reset_in = 1'b0;
        issue_op(14, 4, 1);

        // Start_in held high with operands changing every cycle: one op per W+2 cycles.
        for (int j = 0; j < 6 * (W + 2); j++) begin
            Start_in    = 1'b1;
            Dividend_in = W'($urandom_range(15, 0));
            Divisor_in  = W'($urandom_range(15, 1));
            if (j % (W + 2) == 0) push_op(int'(Dividend_in), int'(Divisor_in), lat);
            @(negedge clk);
        end
        Start_in = 1'b0;
        repeat (2) @(negedge clk);

        // All nonzero-divisor pairs in shuffled order.
        np = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                pa[np] = a;
                pb[np] = b;
                np++;
            end
        end
        for (int i = np - 1; i > 0; i--) begin
            int j;
            int t;
            j     = int'($urandom_range(i, 0));
            t     = pa[i]; pa[i] = pa[j]; pa[j] = t;
            t     = pb[i]; pb[i] = pb[j]; pb[j] = t;
        end
        for (int i = 0; i < np; i++) begin
            issue_op(pa[i], pb[i], int'($urandom_range(1, 0)));
        end

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
